// File: rtl/mcb_pkg.sv
// Shared definitions for the memory-controller user-port responder:
// command encodings, engine state, burst length width and the write-FIFO word layout.
package mcb_pkg;

  localparam logic [2:0] CMD_WR    = 3'b000;
  localparam logic [2:0] CMD_RD    = 3'b001;
  localparam logic [2:0] CMD_WR_AP = 3'b010;
  localparam logic [2:0] CMD_RD_AP = 3'b011;

  localparam int BL_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } eng_state_e;

  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } wr_t;

  // Auto-precharge variants behave exactly like their plain counterparts here.
  function automatic logic is_wr(input logic [2:0] instr);
    return (instr == CMD_WR) || (instr == CMD_WR_AP);
  endfunction

  function automatic logic is_rd(input logic [2:0] instr);
    return (instr == CMD_RD) || (instr == CMD_RD_AP);
  endfunction

endpackage

// File: rtl/mcb_fifo.sv
// Synchronous FIFO with registered read port: dout updates on the edge that pops; holds otherwise.
// Flags and count come from registered state; push when full and pop when empty are ignored.
module mcb_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  dout_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = dout_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
      if (do_pop) begin
        rptr_q <= (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
        dout_q <= mem_q[rptr_q];
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/mcb_port_responder.sv
// Block-RAM backed responder for the memory-controller user port; read data lands 4 cycles after command accept.
// Write bursts stall on an empty write FIFO, read bursts stall when the read FIFO lacks room.
module mcb_port_responder
  import mcb_pkg::*;
#(
  parameter int MEM_AW       = 12,
  parameter int CMD_DEPTH    = 4,
  parameter int WR_DEPTH     = 64,
  parameter int RD_DEPTH     = 64,
  parameter int CALIB_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        calib_done,
  input  logic        cmd_en,
  input  logic [2:0]  cmd_instr,
  input  logic [29:0] cmd_byte_addr,
  input  logic [5:0]  cmd_bl,
  output logic        cmd_full,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_mask,
  output logic        wr_full,
  output logic [6:0]  wr_count,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        rd_empty,
  output logic [6:0]  rd_count,
  output logic        wr_overflow,
  output logic        rd_underflow
);

  typedef struct packed {
    logic [2:0]        instr;
    logic [MEM_AW-1:0] addr;
    logic [BL_W-1:0]   bl;
  } cmd_t;

  localparam int CALW = $clog2(CALIB_CYCLES + 1);
  localparam int CCW  = $clog2(CMD_DEPTH + 1);
  localparam int WCW  = $clog2(WR_DEPTH + 1);
  localparam int RCW  = $clog2(RD_DEPTH + 1);

  logic [CALW-1:0] cal_cnt_q;
  logic            wr_ovf_q, rd_unf_q;

  cmd_t            cmd_in, cmd_head;
  logic            cmd_push, cmd_pop, cmd_ffull, cmd_empty;
  logic [CCW-1:0]  cmd_cnt;

  wr_t             wr_in, wr_head;
  logic            wr_push, wr_pop, wr_ffull, wr_empty;
  logic [WCW-1:0]  wr_cnt;

  logic            rd_ffull;
  logic [RCW-1:0]  rd_cnt;
  logic            rd_space;

  eng_state_e        state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [BL_W-1:0]   left_q, left_d;
  logic              popped_q, popped_d;
  logic              mem_re;

  logic              wr_vld_q;
  logic [MEM_AW-1:0] wr_addr_q;
  logic              rd_inflight_q;
  logic [31:0]       mem_rdata_q;
  logic [31:0]       mem_q [2**MEM_AW];

  logic unused_bits;
  assign unused_bits = ^{cmd_byte_addr[29:MEM_AW+2], cmd_byte_addr[1:0], cmd_cnt, rd_ffull};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cal_cnt_q <= '0;
      wr_ovf_q  <= 1'b0;
      rd_unf_q  <= 1'b0;
    end else begin
      if (!calib_done) cal_cnt_q <= cal_cnt_q + CALW'(1);
      if (wr_en && wr_full && calib_done) wr_ovf_q <= 1'b1;
      if (rd_en && rd_empty) rd_unf_q <= 1'b1;
    end
  end

  // Port stays closed to pushes until calibration completes.
  assign calib_done   = (cal_cnt_q == CALW'(CALIB_CYCLES));
  assign cmd_full     = !calib_done || cmd_ffull;
  assign wr_full      = !calib_done || wr_ffull;
  assign cmd_push     = cmd_en && !cmd_full;
  assign wr_push      = wr_en && !wr_full;
  assign wr_count     = 7'(wr_cnt);
  assign rd_count     = 7'(rd_cnt);
  assign wr_overflow  = wr_ovf_q;
  assign rd_underflow = rd_unf_q;

  assign cmd_in = '{instr: cmd_instr, addr: cmd_byte_addr[MEM_AW+1:2], bl: cmd_bl};
  assign wr_in  = '{mask: wr_mask, data: wr_data};

  mcb_fifo #(.W($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (cmd_push),
    .din_i   (cmd_in),
    .pop_i   (cmd_pop),
    .dout_o  (cmd_head),
    .full_o  (cmd_ffull),
    .empty_o (cmd_empty),
    .count_o (cmd_cnt)
  );

  mcb_fifo #(.W($bits(wr_t)), .DEPTH(WR_DEPTH)) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_push),
    .din_i   (wr_in),
    .pop_i   (wr_pop),
    .dout_o  (wr_head),
    .full_o  (wr_ffull),
    .empty_o (wr_empty),
    .count_o (wr_cnt)
  );

  mcb_fifo #(.W(32), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (rd_inflight_q),
    .din_i   (mem_rdata_q),
    .pop_i   (rd_en),
    .dout_o  (rd_data),
    .full_o  (rd_ffull),
    .empty_o (rd_empty),
    .count_o (rd_cnt)
  );

  // Reserve a slot for the word already travelling out of the RAM.
  assign rd_space = (32'(rd_cnt) + 32'(rd_inflight_q)) < 32'(RD_DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      left_q   <= '0;
      popped_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      left_q   <= left_d;
      popped_q <= popped_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    left_d   = left_q;
    popped_d = popped_q;
    unique case (state_q)
      ST_IDLE: begin
        // The popped command shows on the FIFO read port one cycle after the pop.
        if (popped_q) begin
          popped_d = 1'b0;
          addr_d   = cmd_head.addr;
          left_d   = cmd_head.bl;
          if (is_wr(cmd_head.instr))      state_d = ST_WRITE;
          else if (is_rd(cmd_head.instr)) state_d = ST_READ;
        end else if (!cmd_empty) begin
          popped_d = 1'b1;
        end
      end
      ST_WRITE: begin
        if (!wr_empty) begin
          addr_d = addr_q + MEM_AW'(1);
          left_d = left_q - BL_W'(1);
          if (left_q == '0) state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_space) begin
          addr_d = addr_q + MEM_AW'(1);
          left_d = left_q - BL_W'(1);
          if (left_q == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_pop = (state_q == ST_IDLE) && !popped_q && !cmd_empty;
    wr_pop  = (state_q == ST_WRITE) && !wr_empty;
    mem_re  = (state_q == ST_READ) && rd_space;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_vld_q      <= 1'b0;
      wr_addr_q     <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      wr_vld_q      <= wr_pop;
      rd_inflight_q <= mem_re;
      if (wr_pop) wr_addr_q <= addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld_q) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head.mask[b]) mem_q[wr_addr_q][8*b +: 8] <= wr_head.data[8*b +: 8];
      end
    end
    if (mem_re) mem_rdata_q <= mem_q[addr_q];
  end

endmodule
